// File: rtl/bus_pkg.sv
// Shared constants, command encodings and state type for the shared-bus arbiter.
// Request levels compare numerically: a higher code means a more urgent request.
package bus_pkg;

    localparam int unsigned CmdW  = 3;
    localparam int unsigned LenW  = 2;
    localparam int unsigned DataW = 32;
    localparam int unsigned TarW  = 4;
    localparam int unsigned LvlW  = 2;

    localparam logic [CmdW-1:0] CmdNop    = 3'b000;
    localparam logic [CmdW-1:0] CmdWrReq  = 3'b100;
    localparam logic [CmdW-1:0] CmdWrResp = 3'b101;

    localparam logic [LvlW-1:0] ReqNone = 2'b00;
    localparam logic [LvlW-1:0] ReqLow  = 2'b01;
    localparam logic [LvlW-1:0] ReqMid  = 2'b10;
    localparam logic [LvlW-1:0] ReqHigh = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StAddr,
        StData
    } arb_state_e;

    function automatic logic [LvlW-1:0] lvl_max(input logic [LvlW-1:0] a,
                                                input logic [LvlW-1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/bus_arb_if.sv
// Master-side request bundle and shared-bus outputs of the arbiter.
// The slave modport is the arbiter's view; the master modport is the requesters' view.
interface bus_arb_if
    import bus_pkg::*;
#(
    parameter int unsigned NREQ = 4
);

    logic [LvlW*NREQ-1:0]  m_req;
    logic [LenW*NREQ-1:0]  m_len;
    logic [CmdW*NREQ-1:0]  m_cmd;
    logic [DataW*NREQ-1:0] m_addrdata;
    logic [TarW*NREQ-1:0]  m_tar;

    logic [NREQ-1:0]  gnt;
    logic [CmdW-1:0]  cmdout;
    logic [LenW-1:0]  lenout;
    logic [DataW-1:0] addrdataout;
    logic [TarW-1:0]  selout;
    logic             busy;

    modport slave (
        input  m_req,
        input  m_len,
        input  m_cmd,
        input  m_addrdata,
        input  m_tar,
        output gnt,
        output cmdout,
        output lenout,
        output addrdataout,
        output selout,
        output busy
    );

    modport master (
        output m_req,
        output m_len,
        output m_cmd,
        output m_addrdata,
        output m_tar,
        input  gnt,
        input  cmdout,
        input  lenout,
        input  addrdataout,
        input  selout,
        input  busy
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational priority-then-round-robin picker: highest level wins, ties resolved
// by scanning upward from last_i+1 with wrap. Reusable by any level-based arbiter.
module rr_pick
    import bus_pkg::*;
#(
    parameter int unsigned NReq = 4,
    localparam int unsigned IdxW = (NReq > 1) ? $clog2(NReq) : 1
) (
    input  logic [LvlW*NReq-1:0] req_i,
    input  logic [IdxW-1:0]      last_i,
    output logic [NReq-1:0]      gnt_o,
    output logic [IdxW-1:0]      idx_o,
    output logic                 valid_o
);

    logic [LvlW-1:0] max_lvl;
    logic            found;
    int              j;

    always_comb begin
        max_lvl = ReqNone;
        for (int i = 0; i < int'(NReq); i++) begin
            max_lvl = lvl_max(max_lvl, req_i[LvlW*i +: LvlW]);
        end

        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        j     = 0;
        // k runs 1..NReq so the previous winner is considered last.
        for (int k = 1; k <= int'(NReq); k++) begin
            j = (int'(last_i) + k) % int'(NReq);
            if (!found && (max_lvl != ReqNone) && (req_i[LvlW*j +: LvlW] == max_lvl)) begin
                found    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = IdxW'(j);
            end
        end
        valid_o = found;
    end

endmodule

// File: rtl/bus_arb.sv
// Shared addr/data bus arbiter: one tenure = ADDR cycle + len+1 DATA beats + one IDLE
// turnaround. The bus mux is driven purely from the registered one-hot grant.
module bus_arb
    import bus_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic     clk,
    input  logic     reset,
    bus_arb_if.slave bus
);

    arb_state_e      state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [LenW-1:0] len_q, len_d;
    logic [LenW-1:0] cnt_q, cnt_d;
    logic [IdxW-1:0] last_q, last_d;

    logic [NREQ-1:0] pick_gnt;
    logic [IdxW-1:0] pick_idx;
    logic            pick_valid;
    logic [LenW-1:0] win_len;

    rr_pick #(
        .NReq (NREQ)
    ) u_rr_pick (
        .req_i   (bus.m_req),
        .last_i  (last_q),
        .gnt_o   (pick_gnt),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    always_comb begin
        win_len = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (pick_gnt[i]) begin
                win_len = win_len | bus.m_len[LenW*i +: LenW];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        last_d  = last_q;

        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    state_d = StAddr;
                    gnt_d   = pick_gnt;
                    len_d   = win_len;
                    cnt_d   = win_len;
                    last_d  = pick_idx;
                end
            end
            StAddr: begin
                state_d = StData;
            end
            StData: begin
                if (cnt_q == '0) begin
                    state_d = StIdle;
                    gnt_d   = '0;
                    len_d   = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                gnt_d   = '0;
                len_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            last_q  <= IdxW'(NREQ - 1);
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    // AND-OR mux: an all-zero grant yields NOP / zero on every bus field.
    always_comb begin
        bus.cmdout      = CmdNop;
        bus.addrdataout = '0;
        bus.selout      = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (gnt_q[i]) begin
                bus.cmdout      = bus.cmdout | bus.m_cmd[CmdW*i +: CmdW];
                bus.addrdataout = bus.addrdataout | bus.m_addrdata[DataW*i +: DataW];
                bus.selout      = bus.selout | bus.m_tar[TarW*i +: TarW];
            end
        end
    end

    assign bus.gnt    = gnt_q;
    assign bus.lenout = len_q;
    assign bus.busy   = (state_q != StIdle);

endmodule

// File: tb/tb_bus_arb.sv
// Directed bench for bus_arb: reset, single tenure, priority, round-robin, mux,
// request drop and mid-burst reset, with hand-computed expectations.
module tb_bus_arb;
    import bus_pkg::*;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    bus_arb_if #(.NREQ(4)) bus_if ();

    bus_arb #(.NREQ(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    int n_chk = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input int i, input logic [1:0] lvl, input logic [1:0] len,
                         input logic [2:0] cmd, input logic [31:0] data,
                         input logic [3:0] tar);
        bus_if.m_req[2*i +: 2]       = lvl;
        bus_if.m_len[2*i +: 2]       = len;
        bus_if.m_cmd[3*i +: 3]       = cmd;
        bus_if.m_addrdata[32*i +: 32] = data;
        bus_if.m_tar[4*i +: 4]       = tar;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_gnt"},  32'(bus_if.gnt),    32'h0);
        check({tag, "_busy"}, 32'(bus_if.busy),   32'h0);
        check({tag, "_len"},  32'(bus_if.lenout), 32'h0);
        check({tag, "_cmd"},  32'(bus_if.cmdout), 32'h0);
        check({tag, "_ad"},   bus_if.addrdataout, 32'h0);
        check({tag, "_sel"},  32'(bus_if.selout), 32'h0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    initial begin
        logic [3:0] rr_exp [5];
        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        bus_if.m_req      = '0;
        bus_if.m_len      = '0;
        bus_if.m_cmd      = '0;
        bus_if.m_addrdata = '0;
        bus_if.m_tar      = '0;
        reset = 1'b1;
        #1 reset = 1'b0;
        #1 check_idle("reset");
        tick();
        tick();
        reset = 1'b1;

        // Single master 2, level low, len 1: ADDR + 2 DATA, then idle.
        set_m(2, ReqLow, 2'b01, CmdWrReq, 32'h0000_1000, 4'b0010);
        tick();
        check("single_c1_gnt", 32'(bus_if.gnt), 32'b0100);
        check("single_c1_busy", 32'(bus_if.busy), 32'h1);
        check("single_c1_len", 32'(bus_if.lenout), 32'h1);
        bus_if.m_req = '0;
        tick();
        check("single_c2_busy", 32'(bus_if.busy), 32'h1);
        tick();
        check("single_c3_gnt", 32'(bus_if.gnt), 32'b0100);
        check("single_c3_len", 32'(bus_if.lenout), 32'h1);
        tick();
        check_idle("single_c4");

        // Priority: master 3 high beats master 0 low.
        set_m(0, ReqLow, 2'b00, CmdWrReq, 32'h0, 4'b0001);
        set_m(3, ReqHigh, 2'b00, CmdWrReq, 32'h0, 4'b1000);
        tick();
        check("prio_c1_gnt", 32'(bus_if.gnt), 32'b1000);
        bus_if.m_req[7:6] = ReqNone;
        tick();
        check("prio_c2_gnt", 32'(bus_if.gnt), 32'b1000);
        tick();
        check("prio_c3_gnt", 32'(bus_if.gnt), 32'b0000);
        tick();
        check("prio_c4_gnt", 32'(bus_if.gnt), 32'b0001);
        bus_if.m_req = '0;
        tick();
        tick();
        check("prio_c6_busy", 32'(bus_if.busy), 32'h0);

        // Round-robin from reset: four-way tie at mid, len 0, held continuously.
        do_reset();
        for (int i = 0; i < 4; i++) set_m(i, ReqMid, 2'b00, CmdWrReq, 32'h0, 4'b0001);
        tick();
        for (int k = 0; k < 5; k++) begin
            if (k > 0) begin
                tick();
                tick();
                check($sformatf("rr_idle%0d", k), 32'(bus_if.gnt), 32'h0);
                tick();
            end
            check($sformatf("rr_gnt%0d", k), 32'(bus_if.gnt), 32'(rr_exp[k]));
        end
        bus_if.m_req = '0;
        tick();
        tick();

        // Mux: only master 1's fields may appear on the bus.
        set_m(0, ReqNone, 2'b00, CmdWrResp, 32'hAAAA_0000, 4'b1000);
        set_m(2, ReqNone, 2'b00, CmdWrResp, 32'hCCCC_0000, 4'b0100);
        set_m(3, ReqNone, 2'b00, CmdWrResp, 32'hDDDD_0000, 4'b0010);
        set_m(1, ReqLow, 2'b00, CmdWrReq, 32'h0000_0028, 4'b0001);
        #1 check_idle("mux_pre");
        tick();
        check("mux_addr_cmd", 32'(bus_if.cmdout), 32'(CmdWrReq));
        check("mux_addr_ad", bus_if.addrdataout, 32'h0000_0028);
        check("mux_addr_sel", 32'(bus_if.selout), 32'b0001);
        bus_if.m_req = '0;
        bus_if.m_addrdata[63:32] = 32'h0000_DA7A;
        tick();
        check("mux_data_ad", bus_if.addrdataout, 32'h0000_DA7A);
        check("mux_data_sel", 32'(bus_if.selout), 32'b0001);
        tick();
        check_idle("mux_post");

        // Request drop and len change after grant: all 4 beats still run.
        set_m(0, ReqLow, 2'b11, CmdWrReq, 32'h0000_0100, 4'b0100);
        tick();
        check("drop_addr_gnt", 32'(bus_if.gnt), 32'b0001);
        check("drop_addr_len", 32'(bus_if.lenout), 32'h3);
        bus_if.m_len[1:0] = 2'b00;
        tick();
        bus_if.m_req = '0;
        for (int b = 0; b < 4; b++) begin
            check($sformatf("drop_beat%0d_busy", b), 32'(bus_if.busy), 32'h1);
            check($sformatf("drop_beat%0d_len", b), 32'(bus_if.lenout), 32'h3);
            tick();
        end
        check_idle("drop_end");

        // Reset mid-DATA: outputs clear immediately; afterwards master 0 wins a 4-way tie.
        set_m(2, ReqHigh, 2'b11, CmdWrReq, 32'h1234_5678, 4'b1000);
        tick();
        bus_if.m_req = '0;
        tick();
        tick();
        check("mid_busy_before", 32'(bus_if.busy), 32'h1);
        reset = 1'b0;
        #1 check_idle("mid_reset");
        for (int i = 0; i < 4; i++) bus_if.m_req[2*i +: 2] = ReqHigh;
        #1 reset = 1'b1;
        tick();
        check("post_reset_gnt", 32'(bus_if.gnt), 32'b0001);
        check("post_reset_busy", 32'(bus_if.busy), 32'h1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
